bsg_flow_credit_receiver: RTL and testbench
===========================================

# bsg_flow_credit_receiver

Receiving end of the credit-based flow protocol whose sending end is `bsg_flow_counter`. It accepts valid-only input with no backpressure, because the sender's credit counter guarantees space. Data is buffered in an `els_p`-entry FIFO and presented to a local consumer with a valid/yumi handshake. Each consumed entry is returned to the sender as credit pulses, optionally batched; these pulses drive the sender counter's `yumi_i`.

## Interface
- `width_p`, default 8: data width.
- `els_p`, default 256: FIFO depth. Must equal the sender counter's initial credit value (its `max_val_p`).
- `credit_batch_p`, default 1: entries freed per `credit_o` pulse. Legal range is 1..`els_p`.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `v_i` in 1: an entry is arriving; written unconditionally (sender holds a credit).
- `data_i` in `width_p`: arriving entry.
- `v_o` out 1: FIFO non-empty.
- `data_o` out `width_p`: head entry, valid when `v_o`.
- `yumi_i` in 1: consumer takes the head this cycle. Legal only when `v_o`.
- `credit_o` out 1: single-cycle pulse meaning `credit_batch_p` credits are returned.
- `count_o` out `$clog2(els_p+1)`: current occupancy, 0..`els_p`.
- `overflow_o` out 1: only present with `BSG_FLOW_CREDIT_RX_CHECK_EN`.

## Operation
- **Storage:** circular buffer.
  - `wptr` and `rptr` are each `$clog2(els_p)` bits plus a wrap bit.
  - Full when the indices are equal and the wrap bits differ; empty when both indices and wrap bits are equal.
  - Non-power-of-two `els_p` is supported: the pointer index goes back to 0 after `els_p-1`, and the wrap bit toggles at that point.
- **Write:** when `v_i` and not full, store `data_i` at `wptr` and advance `wptr`.
  - When `v_i` arrives while full, the write is dropped. This is a protocol violation by the sender.
- **Read:** when `yumi_i` and `v_o`, advance `rptr`.
  - When `yumi_i` arrives while empty, nothing changes. This is a protocol violation by the consumer.
- **`count_o`:** updated by +1 on a write, −1 on a read, and unchanged when both happen or neither happens.
- **Simultaneous write and read:**
  - Legal at any non-empty occupancy, including full.
  - When full, the read frees a slot in the same cycle, so the write is accepted.
- **No bypass:** an entry written at cycle t is not readable at cycle t.
- **Credit batcher:**
  - `pending` counts accepted reads, range 0..`credit_batch_p`-1.
  - On an accepted read, if `pending == credit_batch_p-1`: set `pending` to 0 and register `credit_o`=1 for the next cycle. Otherwise `pending` increments.
  - With `credit_batch_p`=1, every read yields one pulse.
- **No deadlock:** once the sender's credits reach 0, draining the FIFO builds `pending` up to at least `credit_batch_p`, because `credit_batch_p` ≤ `els_p`.
- **Reset:**
  - `wptr`, `rptr`, `count_o`, `pending` and `overflow_o` go to 0; `v_o`=0 and `credit_o`=0.
  - FIFO contents and unreturned credits are discarded. This matches the sender counter resetting to `els_p`.
  - Reset mid-operation behaves identically, and reset overrides `v_i`/`yumi_i` in the same cycle.
- **`data_o`:** value while `v_o`=0 is don't-care.

## Timing
- `v_i`@t → `v_o`=1 and `count_o` updated at t+1; `data_o` at t+1 equals `data_i`@t if the FIFO was empty.
- `yumi_i`@t → `rptr`, `count_o` and `v_o` updated at t+1; the next head appears on `data_o` at t+1.
- Credit latency: the batch-completing `yumi_i`@t → `credit_o`=1 at t+1 only.
- Maximum `credit_o` rate is one pulse per `credit_batch_p` cycles.
- Round trip is one cycle in each direction. Full throughput (one entry per cycle) requires `els_p` ≥ 3 with `credit_batch_p`=1.
- `data_o` is a combinational read of storage at `rptr`. All other outputs are registered.

## Configuration
- **`BSG_FLOW_CREDIT_RX_CHECK_EN` defined:**
  - Adds port `overflow_o`, a sticky error flag.
  - It is set on the cycle after a `v_i` while full, or after a `yumi_i` while empty.
  - It is cleared only by reset.
  - The design also adds simulation `$error` messages for the same two events.
- **Not defined:** no port and no checks. Dropped writes and ignored reads behave as described in Operation.

## Structure
- **Package `bsg_flow_pkg`:**
  - Pointer-width and count-width helper functions, based on `$clog2(els_p)` and `$clog2(els_p+1)`.
  - A struct type for a pointer: index plus wrap bit.
  - Shared by the sender counter for `count_o` width consistency.
- **Sub-module `bsg_flow_credit_batcher`:**
  - Takes `clk_i`, `reset_i` and `yumi_i`; produces `credit_o`.
  - Holds the `pending` counter and the registered pulse.
  - Reusable by other receivers.
- The top level holds the storage array and the pointers.

## Test plan
- **Reset then idle:** assert reset for 2 cycles → `v_o`=0, `count_o`=0, `credit_o`=0 for 10 idle cycles.
- **Fill and drain** (`els_p`=4, `credit_batch_p`=1): write 0xA0..0xA3 on consecutive cycles → `count_o`=4. Then yumi every cycle → `data_o` shows 0xA0..0xA3 in order and four `credit_o` pulses appear, each one cycle after its yumi; `count_o` returns to 0.
- **Closed loop with the sender counter** (`els_p`=256): random `v_i`/`yumi_i` for 10k cycles → the sender count plus `count_o` plus `pending` plus in-flight credits always equals 256. No overflow, and data order is preserved across index wrap.
- **Batching** (`credit_batch_p`=4, `els_p`=8): 10 reads → exactly 2 pulses, one cycle after the 4th and 8th reads, with `pending`=2 left. Reset then clears `pending` to 0.
- **Simultaneous write and read at full** (`els_p`=4, full): `v_i`=1 and `yumi_i`=1 for 3 cycles → `count_o` stays 4 and the new data is enqueued; with the check macro, `overflow_o` stays 0.
- **Violation** (check macro defined, FIFO full): `v_i`=1 without yumi → `overflow_o`=1 next cycle, the write is dropped, and `overflow_o` stays 1 until reset.

Source files
------------

// File: rtl/bsg_flow_pkg.sv
// Shared pointer/count helpers for the credit flow sender and receiver.
// Used by bsg_flow_credit_receiver and bsg_flow_counter.
package bsg_flow_pkg;

  localparam int PtrIdxMaxW = 16;

  typedef struct packed {
    logic                  wrap;
    logic [PtrIdxMaxW-1:0] idx;
  } bsg_flow_ptr_t;

  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic int count_width(input int els);
    return $clog2(els + 1);
  endfunction

  // Index wraps after els-1 so non-power-of-two depths work.
  function automatic bsg_flow_ptr_t ptr_next(
    input bsg_flow_ptr_t p,
    input int            els
  );
    bsg_flow_ptr_t n;
    n = p;
    if (p.idx == PtrIdxMaxW'(els - 1)) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx = p.idx + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bsg_flow_credit_batcher.sv
// Collects accepted reads and emits one registered credit pulse
// for every credit_batch_p of them.
module bsg_flow_credit_batcher #(
  parameter int credit_batch_p = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic yumi_i,
  output logic credit_o
);

  localparam int pend_w_lp =
    (credit_batch_p > 1) ? $clog2(credit_batch_p) : 1;
  localparam logic [pend_w_lp-1:0] last_lp =
    pend_w_lp'(credit_batch_p - 1);

  logic [pend_w_lp-1:0] r_pending;
  logic                 r_credit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pending <= '0;
      r_credit  <= 1'b0;
    end else begin
      r_credit <= 1'b0;
      if (yumi_i) begin
        if (r_pending == last_lp) begin
          r_pending <= '0;
          r_credit  <= 1'b1;
        end else begin
          r_pending <= r_pending + 1'b1;
        end
      end
    end
  end

  assign credit_o = r_credit;

endmodule

// File: rtl/bsg_flow_credit_receiver.sv
// Credit-flow receiver: els_p-entry FIFO plus batched credit return.
// Define BSG_FLOW_CREDIT_RX_CHECK_EN for the overflow_o flag and checks.
import bsg_flow_pkg::*;

module bsg_flow_credit_receiver #(
  parameter int width_p        = 8,
  parameter int els_p          = 256,
  parameter int credit_batch_p = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             v_i,
  input  logic [width_p-1:0]               data_i,
  output logic                             v_o,
  output logic [width_p-1:0]               data_o,
  input  logic                             yumi_i,
  output logic                             credit_o,
  output logic [count_width(els_p)-1:0]    count_o
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
  ,
  output logic                             overflow_o
`endif
);

  localparam int ptr_w_lp = ptr_width(els_p);
  localparam int cnt_w_lp = count_width(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  bsg_flow_ptr_t       r_wptr;
  bsg_flow_ptr_t       r_rptr;
  logic [cnt_w_lp-1:0] r_count;
  logic                r_v;

  logic                w_full;
  logic                w_empty;
  logic                w_wr;
  logic                w_rd;
  logic [cnt_w_lp-1:0] w_count_n;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr.idx == r_rptr.idx)
                && (r_wptr.wrap != r_rptr.wrap);

  // A read at full frees the slot this cycle's write lands in.
  assign w_rd = yumi_i && !w_empty;
  assign w_wr = v_i && (!w_full || w_rd);

  always_comb begin
    w_count_n = r_count;
    if (w_wr && !w_rd) begin
      w_count_n = r_count + 1'b1;
    end else if (w_rd && !w_wr) begin
      w_count_n = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_wr) begin
      r_mem[r_wptr.idx[ptr_w_lp-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_v     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= ptr_next(r_wptr, els_p);
      end
      if (w_rd) begin
        r_rptr <= ptr_next(r_rptr, els_p);
      end
      r_count <= w_count_n;
      r_v     <= (w_count_n != '0);
    end
  end

  assign v_o     = r_v;
  assign data_o  = r_mem[r_rptr.idx[ptr_w_lp-1:0]];
  assign count_o = r_count;

  bsg_flow_credit_batcher #(
    .credit_batch_p(credit_batch_p)
  ) u_batcher (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .yumi_i  (w_rd),
    .credit_o(credit_o)
  );

`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
  logic r_overflow;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_overflow <= 1'b0;
    end else if ((v_i && w_full && !w_rd)
              || (yumi_i && w_empty)) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && v_i && w_full && !w_rd) begin
      $error("bsg_flow_credit_receiver: write while full");
    end
    if (!reset_i && yumi_i && w_empty) begin
      $error("bsg_flow_credit_receiver: yumi while empty");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_bsg_flow_credit_receiver.sv
// Scoreboard bench for bsg_flow_credit_receiver across three
// configurations: 4/1, 8/4 and non-power-of-two 6/2.
module tb_bsg_flow_credit_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // dut: els 4, batch 1
  logic       a_rst, a_v, a_y;
  logic [7:0] a_d, a_do;
  logic       a_vo, a_cr;
  logic [2:0] a_cnt;
  // dut_b: els 8, batch 4
  logic       b_rst, b_v, b_y;
  logic [7:0] b_d, b_do;
  logic       b_vo, b_cr;
  logic [3:0] b_cnt;
  // dut_c: els 6, batch 2
  logic       c_rst, c_v, c_y;
  logic [7:0] c_d, c_do;
  logic       c_vo, c_cr;
  logic [2:0] c_cnt;
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
  logic a_ovf, b_ovf, c_ovf;
`endif

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  bsg_flow_credit_receiver #(
    .width_p(8), .els_p(4), .credit_batch_p(1)
  ) dut (
    .clk_i(clk), .reset_i(a_rst), .v_i(a_v), .data_i(a_d),
    .v_o(a_vo), .data_o(a_do), .yumi_i(a_y),
    .credit_o(a_cr), .count_o(a_cnt)
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
    , .overflow_o(a_ovf)
`endif
  );

  bsg_flow_credit_receiver #(
    .width_p(8), .els_p(8), .credit_batch_p(4)
  ) dut_b (
    .clk_i(clk), .reset_i(b_rst), .v_i(b_v), .data_i(b_d),
    .v_o(b_vo), .data_o(b_do), .yumi_i(b_y),
    .credit_o(b_cr), .count_o(b_cnt)
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
    , .overflow_o(b_ovf)
`endif
  );

  bsg_flow_credit_receiver #(
    .width_p(8), .els_p(6), .credit_batch_p(2)
  ) dut_c (
    .clk_i(clk), .reset_i(c_rst), .v_i(c_v), .data_i(c_d),
    .v_o(c_vo), .data_o(c_do), .yumi_i(c_y),
    .credit_o(c_cr), .count_o(c_cnt)
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
    , .overflow_o(c_ovf)
`endif
  );

  task automatic test_reset;
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_v = 1; a_y = 1; a_d = 8'h55;
    b_v = 0; b_y = 0; b_d = 0;
    c_v = 0; c_y = 0; c_d = 0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 0; b_rst = 0; c_rst = 0;
    a_v = 0; a_y = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (a_vo !== 1'b0) $display("FAIL reset_v_o: got %b want 0", a_vo);
      else n_pass++;
      n_total++;
      if (a_cnt !== 3'd0) $display("FAIL reset_count: got %0d want 0", a_cnt);
      else n_pass++;
      n_total++;
      if (a_cr !== 1'b0) $display("FAIL reset_credit: got %b want 0", a_cr);
      else n_pass++;
    end
    n_total++;
    if (b_cnt !== 4'd0 || b_vo !== 1'b0) $display("FAIL reset_b: cnt %0d v %b want 0 0", b_cnt, b_vo);
    else n_pass++;
    n_total++;
    if (c_cnt !== 3'd0 || c_vo !== 1'b0) $display("FAIL reset_c: cnt %0d v %b want 0 0", c_cnt, c_vo);
    else n_pass++;
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) begin
      a_v = 1; a_d = 8'hA0 + 8'(i);
      qa.push_back(a_d);
      if (i == 0) begin
        n_total++;
        if (a_vo !== 1'b0) $display("FAIL no_bypass: v_o %b want 0", a_vo);
        else n_pass++;
      end
      @(posedge clk); #1;
      n_total++;
      if (a_cnt !== 3'(i + 1)) $display("FAIL fill_count: got %0d want %0d", a_cnt, i + 1);
      else n_pass++;
    end
    a_v = 0;
    n_total++;
    if (a_vo !== 1'b1) $display("FAIL fill_v_o: got %b want 1", a_vo);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      a_y = 1;
      n_total++;
      if (a_do !== qa[0]) $display("FAIL drain_data: got %h want %h", a_do, qa[0]);
      else n_pass++;
      void'(qa.pop_front());
      @(posedge clk); #1;
      n_total++;
      if (a_cr !== 1'b1) $display("FAIL drain_credit: got %b want 1", a_cr);
      else n_pass++;
    end
    a_y = 0;
    @(posedge clk); #1;
    n_total++;
    if (a_cr !== 1'b0) $display("FAIL credit_single: got %b want 0", a_cr);
    else n_pass++;
    n_total++;
    if (a_cnt !== 3'd0 || a_vo !== 1'b0) $display("FAIL drain_empty: cnt %0d v %b want 0 0", a_cnt, a_vo);
    else n_pass++;
  endtask

  task automatic test_simul_full;
    for (int i = 0; i < 4; i++) begin
      a_v = 1; a_d = 8'hB0 + 8'(i);
      qa.push_back(a_d);
      @(posedge clk); #1;
    end
    n_total++;
    if (a_cnt !== 3'd4) $display("FAIL full_count: got %0d want 4", a_cnt);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      a_v = 1; a_y = 1; a_d = 8'hC0 + 8'(i);
      n_total++;
      if (a_do !== qa[0]) $display("FAIL simul_data: got %h want %h", a_do, qa[0]);
      else n_pass++;
      void'(qa.pop_front());
      qa.push_back(a_d);
      @(posedge clk); #1;
      n_total++;
      if (a_cnt !== 3'd4) $display("FAIL simul_count: got %0d want 4", a_cnt);
      else n_pass++;
      n_total++;
      if (a_cr !== 1'b1) $display("FAIL simul_credit: got %b want 1", a_cr);
      else n_pass++;
    end
    a_v = 0; a_y = 0;
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
    n_total++;
    if (a_ovf !== 1'b0) $display("FAIL simul_overflow: got %b want 0", a_ovf);
    else n_pass++;
`endif
  endtask

  task automatic test_drop;
    a_v = 1; a_d = 8'hEE;
    @(posedge clk); #1;
    a_v = 0;
    n_total++;
    if (a_cnt !== 3'd4) $display("FAIL drop_count: got %0d want 4", a_cnt);
    else n_pass++;
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
    n_total++;
    if (a_ovf !== 1'b1) $display("FAIL drop_overflow: got %b want 1", a_ovf);
    else n_pass++;
`endif
    for (int i = 0; i < 4; i++) begin
      a_y = 1;
      n_total++;
      if (a_do !== qa[0]) $display("FAIL drop_data: got %h want %h", a_do, qa[0]);
      else n_pass++;
      void'(qa.pop_front());
      @(posedge clk); #1;
    end
    a_y = 0;
    n_total++;
    if (a_cnt !== 3'd0 || a_vo !== 1'b0) $display("FAIL drop_empty: cnt %0d v %b want 0 0", a_cnt, a_vo);
    else n_pass++;
`ifdef BSG_FLOW_CREDIT_RX_CHECK_EN
    n_total++;
    if (a_ovf !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", a_ovf);
    else n_pass++;
    a_rst = 1;
    @(posedge clk); #1;
    a_rst = 0;
    n_total++;
    if (a_ovf !== 1'b0) $display("FAIL overflow_reset: got %b want 0", a_ovf);
    else n_pass++;
`endif
  endtask

  task automatic test_batching;
    int  nrd;
    logic exp_cr;
    nrd = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < (k == 0 ? 8 : 2); i++) begin
        b_v = 1; b_d = 8'h10 + 8'(qb.size()) + 8'(k * 8);
        qb.push_back(b_d);
        @(posedge clk); #1;
        n_total++;
        if (b_cr !== 1'b0) $display("FAIL batch_idle_credit: got %b want 0", b_cr);
        else n_pass++;
      end
      b_v = 0;
      for (int i = 0; i < (k == 0 ? 8 : 2); i++) begin
        b_y = 1;
        n_total++;
        if (b_do !== qb[0]) $display("FAIL batch_data: got %h want %h", b_do, qb[0]);
        else n_pass++;
        void'(qb.pop_front());
        @(posedge clk); #1;
        nrd++;
        exp_cr = (nrd % 4 == 0);
        n_total++;
        if (b_cr !== exp_cr) $display("FAIL batch_credit: read %0d got %b want %b", nrd, b_cr, exp_cr);
        else n_pass++;
      end
      b_y = 0;
    end
    @(posedge clk); #1;
    n_total++;
    if (dut_b.u_batcher.r_pending !== 2'd2) $display("FAIL batch_pending: got %0d want 2", dut_b.u_batcher.r_pending);
    else n_pass++;
    b_rst = 1;
    @(posedge clk); #1;
    b_rst = 0;
    n_total++;
    if (dut_b.u_batcher.r_pending !== 2'd0) $display("FAIL batch_pending_reset: got %0d want 0", dut_b.u_batcher.r_pending);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      b_v = 1; b_d = 8'h60 + 8'(i);
      @(posedge clk); #1;
    end
    b_v = 0;
    for (int i = 0; i < 4; i++) begin
      b_y = 1;
      @(posedge clk); #1;
      exp_cr = (i == 3);
      n_total++;
      if (b_cr !== exp_cr) $display("FAIL batch_after_reset: read %0d got %b want %b", i + 1, b_cr, exp_cr);
      else n_pass++;
    end
    b_y = 0;
  endtask

  task automatic test_closed_loop;
    int   credits;
    int   pend;
    logic exp_cr;
    logic [7:0] nxt;
    credits = 6; pend = 0; nxt = 8'h00;
    for (int cyc = 0; cyc < 3030; cyc++) begin
      c_v = (cyc < 3000) && (credits > 0) && ($urandom_range(0, 3) != 0);
      c_y = (qc.size() > 0) && ($urandom_range(0, 2) != 0);
      c_d = nxt;
      if (c_y) begin
        n_total++;
        if (c_do !== qc[0]) $display("FAIL loop_data: cyc %0d got %h want %h", cyc, c_do, qc[0]);
        else n_pass++;
        void'(qc.pop_front());
      end
      if (c_v) begin
        qc.push_back(c_d);
        nxt = nxt + 8'd1;
        credits--;
      end
      exp_cr = 1'b0;
      if (c_y) begin
        if (pend == 1) begin
          pend = 0;
          exp_cr = 1'b1;
        end else begin
          pend++;
        end
      end
      @(posedge clk); #1;
      n_total++;
      if (c_cr !== exp_cr) $display("FAIL loop_credit: cyc %0d got %b want %b", cyc, c_cr, exp_cr);
      else n_pass++;
      if (c_cr === 1'b1) credits += 2;
      n_total++;
      if (c_cnt !== 3'(qc.size())) $display("FAIL loop_count: cyc %0d got %0d want %0d", cyc, c_cnt, qc.size());
      else n_pass++;
    end
    c_v = 0; c_y = 0;
    n_total++;
    if (qc.size() != 0 || credits + pend != 6)
      $display("FAIL loop_credit_sum: credits %0d pending %0d left %0d want sum 6", credits, pend, qc.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simul_full();
    test_drop();
    test_batching();
    test_closed_loop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
